// File: rtl/dec_sbox_layer_if.sv
// Stream interface for the inverse S-box layer: input block handshake and result handshake.
interface dec_sbox_layer_if #(
  parameter int STATE_W = 64
) ();
  logic               in_valid;
  logic               in_ready;
  logic [STATE_W-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/dec_sbox_layer.sv
// Inverse S-box layer: substitutes LANES nibbles per cycle through a reloadable 16x4 table.
//
// state | meaning
// IDLE  | ready for a new block; table writes accepted
// BUSY  | substituting LANES nibbles per cycle, LSB-first
// DONE  | result presented on out_data until out_ready
module dec_sbox_layer #(
  parameter int          STATE_W   = 64,
  parameter int          LANES     = 4,
  parameter logic [63:0] INV_TABLE = 64'hB086275C4FD1E93A
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dec_sbox_layer_if.slave      bus,
  input  logic                 tbl_we,
  input  logic [3:0]           tbl_addr,
  input  logic [3:0]           tbl_wdata,
  output logic                 tbl_err,
  output logic                 busy
);

  localparam int NIB   = STATE_W / 4;
  localparam int BEATS = STATE_W / (4 * LANES);
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      beat;
  logic [STATE_W-1:0] work;
  logic [STATE_W-1:0] sub_word;
  logic [3:0]         tbl [16];
  logic               accept;
  logic               last_beat;
  logic               in_ready;
  logic               out_valid;

  // Only the nibbles belonging to the current beat are replaced; the rest pass through.
  for (genvar n = 0; n < NIB; n++) begin : g_nib
    assign sub_word[4*n +: 4] = (beat == CW'(n / LANES)) ? tbl[work[4*n +: 4]] : work[4*n +: 4];
  end

  assign accept    = bus.in_valid && in_ready;
  assign last_beat = (beat == CW'(BEATS - 1));

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (last_beat) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      beat    <= '0;
      work    <= '0;
      tbl_err <= 1'b0;
      for (int i = 0; i < 16; i++) tbl[i] <= INV_TABLE[4*i +: 4];
    end else begin
      state   <= state_nxt;
      tbl_err <= tbl_we && (state != IDLE);
      if (tbl_we && (state == IDLE)) tbl[tbl_addr] <= tbl_wdata;
      if (accept) begin
        work <= bus.in_data;
        beat <= '0;
      end else if (state == BUSY) begin
        work <= sub_word;
        beat <= last_beat ? '0 : beat + 1'b1;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = work;

endmodule

// File: tb/tb_dec_sbox_layer.sv
// Directed bench for dec_sbox_layer: default and reloaded tables, stall, table errors, reset, LANES=16.
module tb_dec_sbox_layer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tbl_we = 1'b0;
  logic [3:0] tbl_addr = '0;
  logic [3:0] tbl_wdata = '0;
  logic tbl_err, busy;
  logic tbl_err2, busy2;

  int n_chk = 0;
  int n_pass = 0;
  int lat;
  logic flag;
  logic [63:0] held;
  logic [8:0] vpat;
  int n_acc;
  logic [3:0] fwd [16] = '{4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
                           4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6};

  always #5 clk = ~clk;

  dec_sbox_layer_if #(.STATE_W(64)) bus ();
  dec_sbox_layer_if #(.STATE_W(64)) bus2 ();

  dec_sbox_layer #(.STATE_W(64), .LANES(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .tbl_err(tbl_err), .busy(busy)
  );

  dec_sbox_layer #(.STATE_W(64), .LANES(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave),
    .tbl_we(1'b0), .tbl_addr(4'h0), .tbl_wdata(4'h0),
    .tbl_err(tbl_err2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a block and returns 1ns after the edge that accepted it.
  task automatic accept(input logic [63:0] d);
    int guard = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && guard < 20) begin
      tick();
      guard++;
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int start, output int l, output logic ir_seen);
    l = start;
    ir_seen = 1'b0;
    while (!bus.out_valid && l < 20) begin
      tick();
      l++;
      ir_seen = ir_seen | bus.in_ready;
    end
  endtask

  task automatic twrite(input logic [3:0] a, input logic [3:0] d);
    tbl_we    = 1'b1;
    tbl_addr  = a;
    tbl_wdata = d;
    tick();
    tbl_we = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.out_ready = 1'b1;
    tick(); tick();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_tbl_err", 64'(tbl_err), 64'd0);
    rst_n = 1'b1;
    tick();

    // default table
    accept(64'h0123456789ABCDEF);
    chk("t1_busy", 64'(busy), 64'd1);
    wait_out(0, lat, flag);
    chk("t1_latency", 64'(lat), 64'd4);
    chk("t1_in_ready_low", 64'(flag), 64'd0);
    chk("t1_out_data", bus.out_data, 64'hA39E1DF4C572680B);
    tick();
    chk("t1_back_idle", 64'(bus.in_ready), 64'd1);
    chk("t1_valid_drop", 64'(bus.out_valid), 64'd0);

    // reload with the forward table
    for (int i = 0; i < 16; i++) twrite(4'(i), fwd[i]);
    chk("t2_no_err", 64'(tbl_err), 64'd0);
    accept(64'hA39E1DF4C572680B);
    wait_out(0, lat, flag);
    chk("t2_latency", 64'(lat), 64'd4);
    chk("t2_out_data", bus.out_data, 64'h0123456789ABCDEF);
    tick();

    // stalled output
    bus.out_ready = 1'b0;
    accept(64'h0123456789ABCDEF);
    wait_out(0, lat, flag);
    chk("t3_out_data", bus.out_data, 64'hE4B179CAD20F8536);
    held = bus.out_data;
    flag = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = (c < 2);
      bus.in_data  = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
      flag = flag & bus.out_valid & (bus.out_data == held) & !bus.in_ready;
    end
    bus.in_valid = 1'b0;
    chk("t3_stall_stable", 64'(flag), 64'd1);
    bus.out_ready = 1'b1;
    #1;
    chk("t3_ready_pre_hs", 64'(bus.in_ready), 64'd0);
    tick();
    chk("t3_valid_drop", 64'(bus.out_valid), 64'd0);
    chk("t3_ready_post_hs", 64'(bus.in_ready), 64'd1);
    tick();
    chk("t3_no_extra_accept", 64'(busy), 64'd0);

    // table write while busy is rejected
    accept(64'hA39E1DF4C572680B);
    tbl_we = 1'b1; tbl_addr = 4'h0; tbl_wdata = 4'h5;
    tick();
    tbl_we = 1'b0;
    chk("t4_err_pulse", 64'(tbl_err), 64'd1);
    tick();
    chk("t4_err_clear", 64'(tbl_err), 64'd0);
    wait_out(2, lat, flag);
    chk("t4_latency", 64'(lat), 64'd4);
    chk("t4_unchanged", bus.out_data, 64'h0123456789ABCDEF);
    tick();
    // write in IDLE on the same edge as acceptance
    tbl_we = 1'b1; tbl_addr = 4'h0; tbl_wdata = 4'h5;
    accept(64'h0);
    tbl_we = 1'b0;
    chk("t4_idle_no_err", 64'(tbl_err), 64'd0);
    wait_out(0, lat, flag);
    chk("t4_same_edge", bus.out_data, 64'h5555555555555555);
    tick();

    // reset mid-operation
    accept(64'h0123456789ABCDEF);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("t5_rst_ready", 64'(bus.in_ready), 64'd1);
    tick();
    rst_n = 1'b1;
    flag = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      flag = flag | bus.out_valid;
    end
    chk("t5_no_valid", 64'(flag), 64'd0);
    accept(64'h0);
    wait_out(0, lat, flag);
    chk("t5_latency", 64'(lat), 64'd4);
    chk("t5_default_tbl", bus.out_data, 64'hAAAAAAAAAAAAAAAA);
    tick();

    // LANES=16 back-to-back
    bus2.in_valid = 1'b1;
    bus2.in_data  = 64'h0123456789ABCDEF;
    vpat = '0;
    n_acc = 0;
    flag = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (bus2.in_ready) n_acc++;
      tick();
      vpat[c] = bus2.out_valid;
      if (bus2.out_valid) flag = flag & (bus2.out_data == 64'hA39E1DF4C572680B);
    end
    bus2.in_valid = 1'b0;
    chk("l16_valid_pattern", 64'(vpat), 64'(9'b010010010));
    chk("l16_accepts", 64'(n_acc), 64'd3);
    chk("l16_out_data", 64'(flag), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
